// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: op codes and FSM state encoding.
// ALU control imports the same op-code constants so both ends agree on encoding.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_MUL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_t;

   // True for the only multi-cycle op code.
   function automatic logic is_mul(input logic [2:0] op);
      return (op == ALU_MUL);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result bundle between the ID/EX stage and the execute ALU.
// master = upstream pipeline driving operands, slave = alu_mc.
// With ALU_OVF_EN defined the bundle also carries the registered overflow flag ovf_o.
interface alu_mc_if #(
   parameter int WIDTH = 32
) ();
   logic             valid_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic             flush_i;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;
   logic             valid_o;
   logic             stall_o;
`ifdef ALU_OVF_EN
   logic             ovf_o;

   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
      input  data_o, zero_o, valid_o, stall_o, ovf_o
   );
   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
      output data_o, zero_o, valid_o, stall_o, ovf_o
   );
`else
   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
      input  data_o, zero_o, valid_o, stall_o
   );
   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
      output data_o, zero_o, valid_o, stall_o
   );
`endif
endinterface

// File: rtl/alu_mc_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks total.
// o_done is raised combinationally on the last iteration; o_product is the final
// accumulate value for that same edge, so the parent can register it directly.
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             i_start,
   input  logic             i_run,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign o_done     = i_run && (r_cnt == LAST_CNT);
   assign o_product  = w_acc_next;

   // Load operands on start, then shift and accumulate once per edge while running.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (i_abort) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (i_run) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         r_cnt    <= o_done ? '0 : (r_cnt + 1'b1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle and/or/add/sub plus an iterative multiply.
// Results, zero flag and a one-cycle valid strobe are registered for EX/MEM.
// stall_o holds the upstream pipeline while a multiply is running.
// Optional: define ALU_OVF_EN to add the registered signed-overflow flag ovf_o.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic    clk_i,
   input  logic    rst_n_i,
   alu_mc_if.slave bus
);
   alu_state_t       r_state;
   alu_state_t       w_state_next;

   logic [WIDTH-1:0] r_data;
   logic             r_zero;
   logic             r_valid;

   logic             w_accept;
   logic             w_start_mul;
   logic             w_accept_alu;
   logic             w_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_product;
   logic [WIDTH-1:0] w_alu_res;

   // New work is only taken in IDLE and never on a flush edge.
   assign w_busy       = (r_state == BUSY);
   assign w_accept     = (r_state == IDLE) && bus.valid_i && !bus.flush_i;
   assign w_start_mul  = w_accept && is_mul(bus.ALUCtrl_i);
   assign w_accept_alu = w_accept && !is_mul(bus.ALUCtrl_i);

   // Single-cycle datapath; unrecognised codes fall through to add.
   always_comb begin
      w_alu_res = bus.data1_i + bus.data2_i;
      case (bus.ALUCtrl_i)
         ALU_AND: w_alu_res = bus.data1_i & bus.data2_i;
         ALU_OR:  w_alu_res = bus.data1_i | bus.data2_i;
         ALU_SUB: w_alu_res = bus.data1_i - bus.data2_i;
         default: w_alu_res = bus.data1_i + bus.data2_i;
      endcase
   end

   mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul_iter (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .i_start   (w_start_mul),
      .i_run     (w_busy),
      .i_abort   (bus.flush_i),
      .i_a       (bus.data1_i),
      .i_b       (bus.data2_i),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: flush beats both a new mul and mul completion.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_start_mul) w_state_next = BUSY;
         BUSY: if (bus.flush_i || w_mul_done) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Result registers: update on a single-cycle op or on the final mul edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_data  <= '0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
      end else if (bus.flush_i) begin
         r_valid <= 1'b0;
      end else if (w_accept_alu) begin
         r_data  <= w_alu_res;
         r_zero  <= (w_alu_res == '0);
         r_valid <= 1'b1;
      end else if (w_busy && w_mul_done) begin
         r_data  <= w_product;
         r_zero  <= (w_product == '0);
         r_valid <= 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign bus.data_o  = r_data;
   assign bus.zero_o  = r_zero;
   assign bus.valid_o = r_valid;
   assign bus.stall_o = w_busy;

`ifdef ALU_OVF_EN
   logic r_ovf;
   logic w_ovf;

   // Signed overflow: add with like-signed operands, or sub with unlike-signed
   // operands, whose result sign differs from operand A.
   always_comb begin
      w_ovf = 1'b0;
      case (bus.ALUCtrl_i)
         ALU_AND, ALU_OR: w_ovf = 1'b0;
         ALU_SUB: w_ovf = (bus.data1_i[WIDTH-1] != bus.data2_i[WIDTH-1]) &&
                          (w_alu_res[WIDTH-1] != bus.data1_i[WIDTH-1]);
         default: w_ovf = (bus.data1_i[WIDTH-1] == bus.data2_i[WIDTH-1]) &&
                          (w_alu_res[WIDTH-1] != bus.data1_i[WIDTH-1]);
      endcase
   end

   // Overflow flag registered alongside data_o; multiplies always clear it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ovf <= 1'b0;
      end else if (bus.flush_i) begin
         r_ovf <= r_ovf;
      end else if (w_accept_alu) begin
         r_ovf <= w_ovf;
      end else if (w_busy && w_mul_done) begin
         r_ovf <= 1'b0;
      end
   end

   assign bus.ovf_o = r_ovf;
`endif

endmodule
